anc_sequencer: RTL
==================

Name: anc_sequencer

Overview:
- Per-sample scheduler for the noise-cancellation datapath. Each new I2S sample runs this chain in strict order: lowpass, then sample-buffer write, then LMS weight update, then FIR output.
- It turns the I2S new-sample pulse into one-cycle start strobes for each stage and waits on each stage's done pulse.
- It buffers one early sample, counts overruns and aborts stalled frames with a watchdog.
- It sits between i2s_receiver and the lowpass/sampler/LMS/FIR blocks and replaces their direct pulse chaining.

Parameters:
- TIMEOUT_CYCLES, 1500, max cycles from lp_start_out to fir_done_in before abort (sample period is 1562 cycles at 100 MHz / 64 kHz).
- CNT_W, 8, width of the saturating overrun and timeout counters.

Ports:
- clk_in  input  1  100 MHz system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- sample_pulse_in  input  1  one-cycle new-sample strobe from the I2S receiver.
- adapt_en_in  input  1  1 = run the LMS update this frame; 0 = freeze weights and skip LMS.
- lp_done_in  input  1  lowpass done pulse.
- lms_done_in  input  1  LMS done pulse.
- fir_done_in  input  1  FIR done pulse.
- clear_in  input  1  synchronous clear of sticky flags and counters.
- lp_start_out  output  1  one-cycle start strobe to the lowpass.
- smp_wr_out  output  1  one-cycle write strobe to the sample buffer.
- lms_start_out  output  1  one-cycle start strobe to LMS.
- fir_start_out  output  1  one-cycle start strobe to the FIR.
- out_valid_out  output  1  one-cycle pulse: speaker sample updated.
- busy_out  output  1  high in any state other than IDLE.
- timeout_flag_out  output  1  sticky: at least one frame aborted.
- overrun_cnt_out  output  CNT_W  dropped samples, saturating.
- timeout_cnt_out  output  CNT_W  aborted frames, saturating.

Behaviour:
- Reset (rst_n_in=0, asynchronous): state=IDLE; all strobes, busy_out, timeout_flag_out, pending flag, watchdog counter, overrun_cnt_out and timeout_cnt_out = 0. Reset takes effect mid-frame; no strobe is emitted during or immediately after reset.
- All outputs are registered. Every strobe is exactly 1 cycle wide.
- States: IDLE, LP_WAIT, SMP, LMS_WAIT, FIR_WAIT, DONE.
- IDLE:
  - sample_pulse_in or pending=1 at cycle t: lp_start_out=1 at t+1; state becomes LP_WAIT.
  - adapt_en_in is latched into adapt_q at t.
  - pending is cleared at t.
- LP_WAIT: lp_done_in at cycle k: smp_wr_out=1 at k+1; state becomes SMP.
- SMP (exactly 1 cycle, at k+1):
  - adapt_q=1: lms_start_out=1 at k+2; state becomes LMS_WAIT.
  - adapt_q=0: fir_start_out=1 at k+2; state becomes FIR_WAIT.
- LMS_WAIT: lms_done_in at m: fir_start_out=1 at m+1; state becomes FIR_WAIT.
- FIR_WAIT: fir_done_in at n: out_valid_out=1 at n+1 (DONE state); state returns to IDLE at n+2.
- Done inputs arriving outside their own wait state are ignored.
- Watchdog:
  - Counter is reset to 0 on the cycle lp_start_out=1 and increments every cycle while not IDLE.
  - When counter == TIMEOUT_CYCLES-1 with no done input for the current state that cycle: next cycle state=IDLE, no further strobes, timeout_flag_out=1, timeout_cnt_out increments.
  - A done input in the same cycle as expiry wins; the frame continues.
- Overrun:
  - sample_pulse_in while busy and pending=0: pending is set.
  - sample_pulse_in while busy and pending=1: sample dropped; overrun_cnt_out increments.
  - A pending sample starts immediately from IDLE, with lp_start_out 1 cycle after entering IDLE.
  - sample_pulse_in in the DONE cycle counts as busy.
- Counters saturate at 2^CNT_W-1.
- clear_in zeroes timeout_flag_out and both counters only. It does not affect state or pending. If clear_in and an increment occur in the same cycle, clear wins.
- adapt_en_in changes mid-frame take effect at the next frame start.

Test Plan:
- Basic frame with adapt: rst_n_in low, then high; sample_pulse at t=10, lp_done at 20, lms_done at 300, fir_done at 600 -> lp_start at 11, smp_wr at 21, lms_start at 22, fir_start at 301, out_valid at 601, busy_out low at 602.
- Bypass: adapt_en_in=0 at the sample; lp_done at 20 -> smp_wr at 21, fir_start at 22, lms_start never asserted.
- Overrun: with FIR_WAIT held, three extra sample pulses -> pending set, overrun_cnt_out=2; after fir_done, out_valid pulses, then lp_start 1 cycle after IDLE.
- Timeout: TIMEOUT_CYCLES=1500, lms_done withheld -> abort 1500 cycles after lp_start, timeout_flag_out=1, timeout_cnt_out=1, no fir_start. A lms_done exactly on the expiry cycle -> no abort.
- Saturation and clear: CNT_W=8, 300 dropped samples -> overrun_cnt_out=255; clear_in asserted concurrently with a drop -> counter reads 0.
- Async reset in LMS_WAIT, released after 3 cycles -> all outputs 0 and a later lms_done_in is ignored; the next sample_pulse runs a clean frame.

Source files
------------

// File: rtl/anc_sequencer.sv
// Per-sample scheduler for the ANC datapath: lowpass -> sample write -> LMS -> FIR.
// Emits one-cycle start strobes, buffers one early sample and aborts stalled frames.
module anc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1500,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             sample_pulse_in,
  input  logic             adapt_en_in,
  input  logic             lp_done_in,
  input  logic             lms_done_in,
  input  logic             fir_done_in,
  input  logic             clear_in,
  output logic             lp_start_out,
  output logic             smp_wr_out,
  output logic             lms_start_out,
  output logic             fir_start_out,
  output logic             out_valid_out,
  output logic             busy_out,
  output logic             timeout_flag_out,
  output logic [CNT_W-1:0] overrun_cnt_out,
  output logic [CNT_W-1:0] timeout_cnt_out
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LP_WAIT,
    SMP,
    LMS_WAIT,
    FIR_WAIT,
    DONE
  } state_t;

  state_t           r_state;
  logic             r_pending;
  logic             r_adapt_q;
  logic [WD_W-1:0]  r_wd;
  logic             r_lp_start;
  logic             r_smp_wr;
  logic             r_lms_start;
  logic             r_fir_start;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_to_flag;
  logic [CNT_W-1:0] r_ovr_cnt;
  logic [CNT_W-1:0] r_to_cnt;

  logic w_done_cur;
  logic w_expire;
  logic w_abort;
  logic w_ovr_inc;

  always_comb begin
    w_done_cur = 1'b0;
    case (r_state)
      LP_WAIT:  w_done_cur = lp_done_in;
      LMS_WAIT: w_done_cur = lms_done_in;
      FIR_WAIT: w_done_cur = fir_done_in;
      default:  w_done_cur = 1'b0;
    endcase
    w_expire  = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
    // A done pulse on the expiry cycle rescues the frame; DONE is never aborted.
    w_abort   = w_expire && !w_done_cur &&
                (r_state inside {LP_WAIT, SMP, LMS_WAIT, FIR_WAIT});
    w_ovr_inc = sample_pulse_in && (r_state != IDLE) && r_pending;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= IDLE;
      r_pending   <= 1'b0;
      r_adapt_q   <= 1'b0;
      r_wd        <= '0;
      r_lp_start  <= 1'b0;
      r_smp_wr    <= 1'b0;
      r_lms_start <= 1'b0;
      r_fir_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_lp_start  <= 1'b0;
      r_smp_wr    <= 1'b0;
      r_lms_start <= 1'b0;
      r_fir_start <= 1'b0;
      r_out_valid <= 1'b0;

      // Watchdog holds at all-ones so a rescued frame never re-expires by wrap.
      if (r_state != IDLE && r_wd != '1) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if (r_state != IDLE && sample_pulse_in && !r_pending) begin
        r_pending <= 1'b1;
      end

      if (w_abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (sample_pulse_in || r_pending) begin
              r_state    <= LP_WAIT;
              r_lp_start <= 1'b1;
              r_busy     <= 1'b1;
              r_wd       <= '0;
              r_adapt_q  <= adapt_en_in;
              // A fresh pulse arriving while a pending sample launches becomes the new pending one.
              r_pending  <= r_pending && sample_pulse_in;
            end
          end
          LP_WAIT: begin
            if (lp_done_in) begin
              r_state  <= SMP;
              r_smp_wr <= 1'b1;
            end
          end
          SMP: begin
            if (r_adapt_q) begin
              r_state     <= LMS_WAIT;
              r_lms_start <= 1'b1;
            end else begin
              r_state     <= FIR_WAIT;
              r_fir_start <= 1'b1;
            end
          end
          LMS_WAIT: begin
            if (lms_done_in) begin
              r_state     <= FIR_WAIT;
              r_fir_start <= 1'b1;
            end
          end
          FIR_WAIT: begin
            if (fir_done_in) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_to_flag <= 1'b0;
      r_to_cnt  <= '0;
      r_ovr_cnt <= '0;
    end else if (clear_in) begin
      r_to_flag <= 1'b0;
      r_to_cnt  <= '0;
      r_ovr_cnt <= '0;
    end else begin
      if (w_abort) begin
        r_to_flag <= 1'b1;
        if (r_to_cnt != '1) begin
          r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
      end
      if (w_ovr_inc && r_ovr_cnt != '1) begin
        r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);
      end
    end
  end

  assign lp_start_out     = r_lp_start;
  assign smp_wr_out       = r_smp_wr;
  assign lms_start_out    = r_lms_start;
  assign fir_start_out    = r_fir_start;
  assign out_valid_out    = r_out_valid;
  assign busy_out         = r_busy;
  assign timeout_flag_out = r_to_flag;
  assign overrun_cnt_out  = r_ovr_cnt;
  assign timeout_cnt_out  = r_to_cnt;

endmodule
